// File: rtl/oled_power_sequencer.sv
// ---------------------------------------------------------------------------
// oled_power_sequencer
//
// Brings an SSD1306 panel up and down in the order the panel needs:
// VDD on, RES# pulse, init command stream, VBAT on, display on.
// Power-down is the reverse: display off, VBAT off, then VDD off.
// The block owns the byte channel into the SPI byte sender. The display
// content client reaches that channel only once the panel is fully up (RUN).
//
// Optional build macro: OLED_SEQ_CONTRAST_EN
//   When defined, the block adds a contrast_in port. The init stream then
//   ends with 0x81 followed by the contrast byte. The contrast byte is
//   sampled when the 0x81 byte is accepted.
//
// Ports
//   clk_in            system clock (1 MHz reference)
//   resetn_in         synchronous active-low reset
//   power_on_in       level request: 1 = panel up, 0 = panel down
//   oled_rstn_out     panel RES#
//   oled_vcdn_out     VDD enable, active-low
//   oled_vbatn_out    VBAT enable, active-low
//   byte_out          byte to the SPI sender
//   dc_out            0 = command, 1 = data
//   byte_valid_out    byte_out/dc_out valid
//   byte_ready_in     SPI sender accepts the byte
//   client_byte_in    client byte
//   client_dc_in      client D/C
//   client_valid_in   client byte valid
//   client_ready_out  client byte accepted
//   contrast_in       contrast byte (only with OLED_SEQ_CONTRAST_EN)
//   panel_up_out      high only in RUN
//   busy_out          high in every state except OFF and RUN
// ---------------------------------------------------------------------------
module oled_power_sequencer #(
  parameter int T_VDD_CYCLES  = 1000,
  parameter int T_RST_CYCLES  = 10,
  parameter int T_VBAT_CYCLES = 100000,
  parameter int CNT_W         = 24
) (
  input  logic       clk_in,
  input  logic       resetn_in,
  input  logic       power_on_in,
  output logic       oled_rstn_out,
  output logic       oled_vcdn_out,
  output logic       oled_vbatn_out,
  output logic [7:0] byte_out,
  output logic       dc_out,
  output logic       byte_valid_out,
  input  logic       byte_ready_in,
  input  logic [7:0] client_byte_in,
  input  logic       client_dc_in,
  input  logic       client_valid_in,
  output logic       client_ready_out,
`ifdef OLED_SEQ_CONTRAST_EN
  input  logic [7:0] contrast_in,
`endif
  output logic       panel_up_out,
  output logic       busy_out
);

  typedef enum logic [3:0] {
    S_OFF,
    S_VDD_WAIT,
    S_RST_LOW,
    S_RST_WAIT,
    S_INIT,
    S_VBAT_WAIT,
    S_DISP_ON,
    S_RUN,
    S_DISP_OFF,
    S_VBAT_OFF,
    S_VDD_OFF
  } state_t;

  // Timed states load N-1 on entry and leave when the counter reaches zero,
  // which makes each one last exactly N cycles.
  localparam logic [CNT_W-1:0] C_VDD  = CNT_W'(T_VDD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_RST  = CNT_W'(T_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_VBAT = CNT_W'(T_VBAT_CYCLES - 1);

`ifdef OLED_SEQ_CONTRAST_EN
  localparam logic [3:0] INIT_LAST = 4'd9;
`else
  localparam logic [3:0] INIT_LAST = 4'd7;
`endif

  localparam logic [7:0] CMD_DISP_ON  = 8'hAF;
  localparam logic [7:0] CMD_DISP_OFF = 8'hAE;

  // Fixed part of the init command stream. Index 9 (the contrast value) is
  // not a constant, so it is loaded from contrast_in directly.
  function automatic logic [7:0] init_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    init_byte = 8'h8D;
      4'd1:    init_byte = 8'h14;
      4'd2:    init_byte = 8'hD9;
      4'd3:    init_byte = 8'hF1;
      4'd4:    init_byte = 8'hA1;
      4'd5:    init_byte = 8'hC8;
      4'd6:    init_byte = 8'hDA;
      4'd7:    init_byte = 8'h20;
      4'd8:    init_byte = 8'h81;
      default: init_byte = 8'h00;
    endcase
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_idx;
  logic [7:0]       r_byte;
  logic             r_dc;
  logic             r_valid;
  logic             r_rstn;
  logic             r_vcdn;
  logic             r_vbatn;
  logic             r_panel_up;
  logic             r_busy;

  logic [3:0] w_idx_nxt;
  logic [7:0] w_init_nxt;
  logic       w_cnt_done;
  logic       w_run;

  assign w_idx_nxt  = r_idx + 4'd1;
  assign w_cnt_done = (r_cnt == '0);
  assign w_run      = (r_state == S_RUN);

`ifdef OLED_SEQ_CONTRAST_EN
  // The contrast byte is sampled at the moment the 0x81 byte is accepted.
  assign w_init_nxt = (r_idx == 4'd8) ? contrast_in : init_byte(w_idx_nxt);
`else
  assign w_init_nxt = init_byte(w_idx_nxt);
`endif

  always_ff @(posedge clk_in) begin
    if (!resetn_in) begin
      r_state    <= S_OFF;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_byte     <= 8'h00;
      r_dc       <= 1'b0;
      r_valid    <= 1'b0;
      r_rstn     <= 1'b1;
      r_vcdn     <= 1'b1;
      r_vbatn    <= 1'b1;
      r_panel_up <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_OFF: begin
          if (power_on_in) begin
            r_state <= S_VDD_WAIT;
            r_vcdn  <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= C_VDD;
          end
        end

        S_VDD_WAIT, S_RST_LOW, S_RST_WAIT: begin
          if (!power_on_in) begin
            // Abort before any command went out: drop VDD, release RES#.
            r_state <= S_VDD_OFF;
            r_vcdn  <= 1'b1;
            r_rstn  <= 1'b1;
            r_cnt   <= C_VDD;
          end else if (!w_cnt_done) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (r_state == S_VDD_WAIT) begin
            r_state <= S_RST_LOW;
            r_rstn  <= 1'b0;
            r_cnt   <= C_RST;
          end else if (r_state == S_RST_LOW) begin
            r_state <= S_RST_WAIT;
            r_rstn  <= 1'b1;
            r_cnt   <= C_RST;
          end else begin
            r_state <= S_INIT;
            r_idx   <= '0;
            r_valid <= 1'b0;
          end
        end

        S_INIT: begin
          if (!r_valid) begin
            // First INIT cycle: load byte 0 into the output register.
            if (!power_on_in) begin
              r_state <= S_VDD_OFF;
              r_vcdn  <= 1'b1;
              r_idx   <= '0;
              r_cnt   <= C_VDD;
            end else begin
              r_byte  <= init_byte(r_idx);
              r_dc    <= 1'b0;
              r_valid <= 1'b1;
            end
          end else if (byte_ready_in) begin
            if (!power_on_in) begin
              // The in-flight byte has just been accepted; stop here.
              r_state <= S_VDD_OFF;
              r_vcdn  <= 1'b1;
              r_valid <= 1'b0;
              r_idx   <= '0;
              r_cnt   <= C_VDD;
            end else if (r_idx == INIT_LAST) begin
              r_state <= S_VBAT_WAIT;
              r_vbatn <= 1'b0;
              r_valid <= 1'b0;
              r_idx   <= '0;
              r_cnt   <= C_VBAT;
            end else begin
              // Next byte is presented the cycle after acceptance.
              r_idx  <= w_idx_nxt;
              r_byte <= w_init_nxt;
            end
          end
        end

        S_VBAT_WAIT: begin
          if (!power_on_in) begin
            r_state <= S_VBAT_OFF;
            r_vbatn <= 1'b1;
            r_cnt   <= C_VBAT;
          end else if (!w_cnt_done) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= S_DISP_ON;
            r_byte  <= CMD_DISP_ON;
            r_dc    <= 1'b0;
            r_valid <= 1'b1;
          end
        end

        S_DISP_ON: begin
          // 0xAF always completes; power_on_in only picks the next state.
          if (byte_ready_in) begin
            r_valid <= 1'b0;
            if (!power_on_in) begin
              r_state <= S_VBAT_OFF;
              r_vbatn <= 1'b1;
              r_cnt   <= C_VBAT;
            end else begin
              r_state    <= S_RUN;
              r_panel_up <= 1'b1;
              r_busy     <= 1'b0;
            end
          end
        end

        S_RUN: begin
          // A client transfer in this cycle completes at this edge, because
          // the channel is a pass-through, so leaving now drops nothing.
          if (!power_on_in) begin
            r_state    <= S_DISP_OFF;
            r_panel_up <= 1'b0;
            r_busy     <= 1'b1;
            r_byte     <= CMD_DISP_OFF;
            r_dc       <= 1'b0;
            r_valid    <= 1'b1;
          end
        end

        S_DISP_OFF: begin
          if (byte_ready_in) begin
            r_state <= S_VBAT_OFF;
            r_valid <= 1'b0;
            r_vbatn <= 1'b1;
            r_cnt   <= C_VBAT;
          end
        end

        S_VBAT_OFF: begin
          if (!w_cnt_done) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= S_VDD_OFF;
            r_vcdn  <= 1'b1;
            r_cnt   <= C_VDD;
          end
        end

        S_VDD_OFF: begin
          if (!w_cnt_done) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= S_OFF;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state    <= S_OFF;
          r_valid    <= 1'b0;
          r_rstn     <= 1'b1;
          r_vcdn     <= 1'b1;
          r_vbatn    <= 1'b1;
          r_panel_up <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // In RUN the client drives the channel combinationally.
  assign byte_out         = w_run ? client_byte_in  : r_byte;
  assign dc_out           = w_run ? client_dc_in    : r_dc;
  assign byte_valid_out   = w_run ? client_valid_in : r_valid;
  assign client_ready_out = w_run ? byte_ready_in   : 1'b0;

  assign oled_rstn_out  = r_rstn;
  assign oled_vcdn_out  = r_vcdn;
  assign oled_vbatn_out = r_vbatn;
  assign panel_up_out   = r_panel_up;
  assign busy_out       = r_busy;

endmodule

// File: tb/tb_oled_power_sequencer.sv
// ---------------------------------------------------------------------------
// tb_oled_power_sequencer
//
// Bench for oled_power_sequencer with short timing parameters. Expected
// bytes are queued when the stimulus that causes them is driven and are
// popped whenever the channel shows valid && ready.
// ---------------------------------------------------------------------------
module tb_oled_power_sequencer;

  localparam int TV = 4;
  localparam int TR = 3;
  localparam int TB = 10;
`ifdef OLED_SEQ_CONTRAST_EN
  localparam int NI = 10;
`else
  localparam int NI = 8;
`endif

  logic       clk = 1'b0;
  logic       resetn_in;
  logic       power_on_in;
  logic       oled_rstn_out;
  logic       oled_vcdn_out;
  logic       oled_vbatn_out;
  logic [7:0] byte_out;
  logic       dc_out;
  logic       byte_valid_out;
  logic       byte_ready_in;
  logic [7:0] client_byte_in;
  logic       client_dc_in;
  logic       client_valid_in;
  logic       client_ready_out;
  logic       panel_up_out;
  logic       busy_out;
`ifdef OLED_SEQ_CONTRAST_EN
  logic [7:0] contrast_in;
`endif

  always #5 clk = ~clk;

  oled_power_sequencer #(
    .T_VDD_CYCLES (TV),
    .T_RST_CYCLES (TR),
    .T_VBAT_CYCLES(TB),
    .CNT_W        (8)
  ) dut (
    .clk_in          (clk),
    .resetn_in       (resetn_in),
    .power_on_in     (power_on_in),
    .oled_rstn_out   (oled_rstn_out),
    .oled_vcdn_out   (oled_vcdn_out),
    .oled_vbatn_out  (oled_vbatn_out),
    .byte_out        (byte_out),
    .dc_out          (dc_out),
    .byte_valid_out  (byte_valid_out),
    .byte_ready_in   (byte_ready_in),
    .client_byte_in  (client_byte_in),
    .client_dc_in    (client_dc_in),
    .client_valid_in (client_valid_in),
    .client_ready_out(client_ready_out),
`ifdef OLED_SEQ_CONTRAST_EN
    .contrast_in     (contrast_in),
`endif
    .panel_up_out    (panel_up_out),
    .busy_out        (busy_out)
  );

  typedef struct {
    int   cyc;
    logic rstn;
    logic vcdn;
    logic vbatn;
    logic valid;
    logic pu;
    logic busy;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  logic [8:0] exp_q[$];
  logic [7:0] seq[10];
  vec_t       tv[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: resolve any transfer that happens at the coming edge, then
  // advance to 1 time unit past that edge.
  task automatic tick();
    logic [8:0] e;
    #4;
    if (byte_valid_out && byte_ready_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got %0h expected none", {dc_out, byte_out});
      end else begin
        e = exp_q.pop_front();
        chk("sb_byte", {23'd0, dc_out, byte_out}, {23'd0, e});
      end
    end
    if (!oled_vbatn_out) chk("vbat_needs_vdd", {31'd0, oled_vcdn_out}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic push_init();
    for (int i = 0; i < NI; i++) exp_q.push_back({1'b0, seq[i]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n_rst;
    int   n_vbat;
    int   n_val;
    logic found;
    logic vbat_seen;

    seq = '{8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'h81, 8'h7F};
    //          cyc      rstn  vcdn  vbatn valid pu    busy
    tv[0]  = '{0,       1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[2]  = '{4,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[3]  = '{5,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[4]  = '{7,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[5]  = '{8,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[6]  = '{11,      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[7]  = '{12,      1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[8]  = '{11 + NI, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[9]  = '{12 + NI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[10] = '{22 + NI, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[11] = '{23 + NI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    resetn_in       = 1'b0;
    power_on_in     = 1'b0;
    byte_ready_in   = 1'b1;
    client_byte_in  = 8'h00;
    client_dc_in    = 1'b0;
    client_valid_in = 1'b0;
`ifdef OLED_SEQ_CONTRAST_EN
    contrast_in     = 8'h7F;
`endif
    tick();
    tick();
    resetn_in = 1'b1;
    tick();

    // Reset state
    chk("rst_rstn",   oled_rstn_out,    1);
    chk("rst_vcdn",   oled_vcdn_out,    1);
    chk("rst_vbatn",  oled_vbatn_out,   1);
    chk("rst_valid",  byte_valid_out,   0);
    chk("rst_byte",   byte_out,         0);
    chk("rst_cready", client_ready_out, 0);
    chk("rst_busy",   busy_out,         0);

    // Power-up timeline, table driven
    power_on_in = 1'b1;
    push_init();
    exp_q.push_back({1'b0, 8'hAF});
    n_rst  = 0;
    n_vbat = 0;
    n_val  = 0;
    for (int c = 0; c <= 23 + NI; c++) begin
      if (c > 0) tick();
      for (int k = 0; k < 12; k++) begin
        if (tv[k].cyc == c) begin
          chk($sformatf("pu%0d_rstn", c),  oled_rstn_out,  tv[k].rstn);
          chk($sformatf("pu%0d_vcdn", c),  oled_vcdn_out,  tv[k].vcdn);
          chk($sformatf("pu%0d_vbatn", c), oled_vbatn_out, tv[k].vbatn);
          chk($sformatf("pu%0d_valid", c), byte_valid_out, tv[k].valid);
          chk($sformatf("pu%0d_pu", c),    panel_up_out,   tv[k].pu);
          chk($sformatf("pu%0d_busy", c),  busy_out,       tv[k].busy);
        end
      end
      if (!oled_rstn_out) n_rst++;
      if (!oled_vbatn_out && c < 22 + NI) n_vbat++;
      if (byte_valid_out && c >= 11 && c <= 11 + NI) n_val++;
    end
    chk("pu_rst_low_cycles", n_rst, TR);
    chk("pu_vbat_cycles", n_vbat, TB);
    chk("pu_init_valid_cycles", n_val, NI);
    chk("pu_sb_empty", exp_q.size(), 0);

    // RUN pass-through with toggling ready
    client_valid_in = 1'b1;
    client_dc_in    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      client_byte_in = 8'h40 + 8'(i);
      byte_ready_in  = (i % 2 == 0);
      if (byte_ready_in) exp_q.push_back({1'b1, client_byte_in});
      #1;
      chk("run_cready", client_ready_out, byte_ready_in);
      chk("run_dc", dc_out, 1);
      chk("run_byte", byte_out, client_byte_in);
      tick();
    end
    client_valid_in = 1'b0;
    byte_ready_in   = 1'b1;
    tick();
    chk("run_sb_empty", exp_q.size(), 0);

    // Shutdown from RUN
    power_on_in = 1'b0;
    exp_q.push_back({1'b0, 8'hAE});
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) begin
        chk("sd_valid", byte_valid_out, 1);
        chk("sd_byte", byte_out, 8'hAE);
        chk("sd_pu", panel_up_out, 0);
        chk("sd_cready", client_ready_out, 0);
        chk("sd1_vbatn", oled_vbatn_out, 0);
      end
      if (c == 2)  chk("sd2_vbatn", oled_vbatn_out, 1);
      if (c == 11) chk("sd11_vcdn", oled_vcdn_out, 0);
      if (c == 12) chk("sd12_vcdn", oled_vcdn_out, 1);
      if (c == 15) chk("sd15_busy", busy_out, 1);
      if (c == 16) chk("sd16_busy", busy_out, 0);
    end
    chk("sd_sb_empty", exp_q.size(), 0);

    // Backpressure on 0xD9
    power_on_in = 1'b1;
    push_init();
    exp_q.push_back({1'b0, 8'hAF});
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (byte_valid_out && byte_out == 8'hD9) begin
        found = 1'b1;
        break;
      end
    end
    chk("bp_found", found, 1);
    byte_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_byte", byte_out, 8'hD9);
      chk("bp_valid", byte_valid_out, 1);
    end
    byte_ready_in = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (panel_up_out) begin
        found = 1'b1;
        break;
      end
    end
    chk("bp_run", found, 1);
    chk("bp_sb_empty", exp_q.size(), 0);

    // Abort in INIT while byte 3 is stalled
    power_on_in = 1'b0;
    exp_q.push_back({1'b0, 8'hAE});
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (!busy_out) begin
        found = 1'b1;
        break;
      end
    end
    chk("ab_off", found, 1);
    power_on_in = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, seq[i]});
    vbat_seen = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (!oled_vbatn_out) vbat_seen = 1'b1;
      if (byte_valid_out && byte_out == 8'hF1) begin
        found = 1'b1;
        break;
      end
    end
    chk("ab_found", found, 1);
    byte_ready_in = 1'b0;
    tick();
    tick();
    power_on_in = 1'b0;
    tick();
    chk("ab_hold_valid", byte_valid_out, 1);
    chk("ab_hold_byte", byte_out, 8'hF1);
    chk("ab_hold_vcdn", oled_vcdn_out, 0);
    byte_ready_in = 1'b1;
    tick();
    chk("ab_vddoff_vcdn", oled_vcdn_out, 1);
    chk("ab_vddoff_valid", byte_valid_out, 0);
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (!oled_vbatn_out) vbat_seen = 1'b1;
      tick();
      if (!busy_out) begin
        found = 1'b1;
        break;
      end
    end
    chk("ab_off2", found, 1);
    chk("ab_vbat_never", vbat_seen, 0);
    chk("ab_sb_empty", exp_q.size(), 0);

    // Re-power-up restarts at 0x8D
    power_on_in = 1'b1;
    push_init();
    exp_q.push_back({1'b0, 8'hAF});
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (byte_valid_out) begin
        found = 1'b1;
        break;
      end
    end
    chk("rp_found", found, 1);
    chk("rp_first", byte_out, 8'h8D);

    // Reset in the middle of VBAT_WAIT
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (!oled_vbatn_out) begin
        found = 1'b1;
        break;
      end
    end
    chk("rv_vbat", found, 1);
    tick();
    tick();
    tick();
    chk("rv_pending", exp_q.size(), 1);
    resetn_in   = 1'b0;
    power_on_in = 1'b0;
    tick();
    chk("rv_rstn",   oled_rstn_out,    1);
    chk("rv_vcdn",   oled_vcdn_out,    1);
    chk("rv_vbatn",  oled_vbatn_out,   1);
    chk("rv_valid",  byte_valid_out,   0);
    chk("rv_dc",     dc_out,           0);
    chk("rv_byte",   byte_out,         0);
    chk("rv_cready", client_ready_out, 0);
    chk("rv_pu",     panel_up_out,     0);
    chk("rv_busy",   busy_out,         0);
    resetn_in = 1'b1;
    exp_q.delete();
    tick();
    tick();
    chk("rv_stay_off_busy", busy_out, 0);
    chk("rv_stay_off_vcdn", oled_vcdn_out, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oled_power_sequencer.md
Name: oled_power_sequencer

Overview:
- Sequences SSD1306 power-up and power-down: VDD (vcdn), reset pulse, init command stream, VBAT (vbatn), display on/off.
- Owns the byte channel into the SPI byte sender and shares it with the display-content client.
- The client gets the channel only once the panel is fully up.
- Sits between oled_frequency_counter's content generator and the SPI serializer, clocked by the 1 MHz reference clock.

Parameters:
T_VDD_CYCLES, 1000, dwell after VDD on/off (1 ms at 1 MHz)
T_RST_CYCLES, 10, rstn low time and post-release wait
T_VBAT_CYCLES, 100000, dwell after VBAT on/off (100 ms)
CNT_W, 24, delay counter width; must hold the largest T_* value

Ports:
clk_in  in  1  system clock
resetn_in  in  1  synchronous active-low reset
power_on_in  in  1  level request: 1 = panel up, 0 = panel down
oled_rstn_out  out  1  panel RES#
oled_vcdn_out  out  1  VDD enable, active-low
oled_vbatn_out  out  1  VBAT enable, active-low
byte_out  out  8  byte to SPI sender
dc_out  out  1  0 = command, 1 = data
byte_valid_out  out  1  byte_out/dc_out valid
byte_ready_in  in  1  SPI sender accepts byte
client_byte_in  in  8  client byte
client_dc_in  in  1  client D/C
client_valid_in  in  1  client byte valid
client_ready_out  out  1  client byte accepted
panel_up_out  out  1  high only in RUN
busy_out  out  1  high in every state except OFF and RUN

Behaviour:
- Reset (resetn_in low at a clk_in edge) takes effect the next cycle, from any state, including mid-handshake. After reset: state OFF, rstn=1, vcdn=1, vbatn=1, byte_valid=0, dc=0, byte_out=0x00, client_ready=0, panel_up=0, busy=0.
- Timed states load the counter with N-1 on entry and last exactly N cycles.
- States and transitions:
  - OFF: leaves for VDD_WAIT on power_on_in=1.
  - VDD_WAIT: vcdn=0; T_VDD; then RST_LOW.
  - RST_LOW: rstn=0; T_RST; then RST_WAIT.
  - RST_WAIT: rstn=1; T_RST; then INIT.
  - INIT: sends 0x8D,0x14,0xD9,0xF1,0xA1,0xC8,0xDA,0x20 as commands (dc=0). Index 0..7; advance on valid&&ready. After byte 7 transfers, go to VBAT_WAIT.
  - VBAT_WAIT: vbatn=0; T_VBAT; then DISP_ON.
  - DISP_ON: send 0xAF (dc=0); on transfer, go to RUN.
  - RUN: panel_up=1. Combinational pass-through: byte_out=client_byte_in, dc_out=client_dc_in, byte_valid_out=client_valid_in, client_ready_out=byte_ready_in.
  - DISP_OFF: send 0xAE; on transfer, go to VBAT_OFF.
  - VBAT_OFF: vbatn=1; T_VBAT; then VDD_OFF.
  - VDD_OFF: vcdn=1; T_VDD; then OFF.
- Handshake:
  - Sequencer-sourced bytes are registered; byte_out/dc_out stay stable while valid&&!ready.
  - Valid never drops before acceptance; a transfer occurs on a cycle with valid&&ready.
  - Back-to-back transfers allowed: in INIT the next byte is presented the cycle after acceptance.
  - client_ready_out=0 outside RUN.
- power_on_in=0 handling:
  - In RUN: if no client transfer occurs that cycle, go to DISP_OFF. If a client transfer occurs that cycle, finish it and go to DISP_OFF the next cycle.
  - In VDD_WAIT, RST_LOW, RST_WAIT: go to VDD_OFF immediately; rstn returns to 1.
  - In INIT: complete the in-flight byte, then go to VDD_OFF; the INIT index resets.
  - In VBAT_WAIT or DISP_ON: go to VBAT_OFF (in DISP_ON, the pending 0xAF completes first).
  - Shutdown states ignore power_on_in re-assertion until OFF; OFF then re-starts power-up next cycle.
- vbatn=0 implies vcdn=0 in every state. rstn=0 only in RST_LOW.

Optional Feature:
- Macro OLED_SEQ_CONTRAST_EN.
- Defined:
  - Adds port contrast_in (in, 8). INIT is 10 bytes: the 8 listed plus 0x81 and contrast_in, captured when byte 8 transfers.
  - In RUN, a change of contrast_in is not resent. It applies at next power-up.
- Undefined: no port; INIT is 8 bytes.

Test Plan:
- Bench parameters: T_VDD=4, T_RST=3, T_VBAT=10, ready tied 1, power_on 0→1.
- Power-up: vcdn falls 1 cycle after request. rstn low exactly 3 cycles starting 4 cycles later. Bytes 8D 14 D9 F1 A1 C8 DA 20 on 8 consecutive cycles, dc=0. vbatn low 10 cycles, then AF. panel_up=1 at cycle 31 after request.
- Backpressure: ready held 0 for 5 cycles while 0xD9 is presented; byte_out stays 0xD9 and valid stays 1 throughout. Order unchanged; nothing dropped or duplicated.
- RUN pass-through: client sends 0x40 data with ready toggling; client_ready mirrors byte_ready_in; dc_out=1.
- Shutdown from RUN: power_on→0 gives AE, then vbatn=1, then 10 cycles later vcdn=1, then 4 cycles later OFF with busy=0.
- Abort in INIT: power_on→0 while byte 3 is stalled; byte 3 completes, then VDD_OFF with vbatn never 0. A re-power-up restarts INIT at 0x8D.
- Reset mid-VBAT_WAIT: resetn_in=0 for 1 cycle; next cycle all outputs at reset values. With OLED_SEQ_CONTRAST_EN and contrast_in=0x7F, INIT ends with 81 7F.
